eth_xcvr_link_ctrl: RTL and testbench

Bring-up and recovery sequencer for one 10G transceiver channel and its PCS (eth_xcvr_phy_wrapper).
- Orders QPLL reset, TX datapath reset and RX datapath reset.
- Gates the SFP transmitter.
- Watches PCS block lock, high BER and SFP LOS, and re-runs the RX or full reset sequence on failure.
- Sits between the board top level and the PHY wrapper, clocked by the 125 MHz transceiver control clock.

---
 rtl/eth_xcvr_link_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_eth_xcvr_link_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_xcvr_link_ctrl.sv
// Bring-up and recovery sequencer for one 10G transceiver channel and its PCS.
// Orders QPLL/TX/RX resets, gates the SFP laser and re-runs resets when the link degrades.
module eth_xcvr_link_ctrl #(
  parameter int unsigned RESET_HOLD        = 64,
  parameter int unsigned QPLL_LOCK_TIMEOUT = 65536,
  parameter int unsigned RX_LOCK_TIMEOUT   = 1048576,
  parameter int unsigned BER_DEBOUNCE      = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       gtpowergood,
  input  logic       qpll_lock,
  input  logic       rx_block_lock,
  input  logic       rx_high_ber,
  input  logic       sfp_npres,
  input  logic       sfp_los,
  output logic       qpll_reset,
  output logic       tx_reset,
  output logic       rx_reset,
  output logic       sfp_tx_disable,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] retry_count
);

  localparam int unsigned MAX_AB  = (RESET_HOLD > QPLL_LOCK_TIMEOUT) ? RESET_HOLD : QPLL_LOCK_TIMEOUT;
  localparam int unsigned MAX_CD  = (RX_LOCK_TIMEOUT > BER_DEBOUNCE) ? RX_LOCK_TIMEOUT : BER_DEBOUNCE;
  localparam int unsigned MAX_P   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_P) + 1;
  localparam int unsigned SYNC_W  = 6;
  localparam int unsigned RETRY_W = 8;

  localparam int unsigned I_PWRGOOD = 0;
  localparam int unsigned I_QLOCK   = 1;
  localparam int unsigned I_BLOCK   = 2;
  localparam int unsigned I_HIBER   = 3;
  localparam int unsigned I_NPRES   = 4;
  localparam int unsigned I_LOS     = 5;

  // Module-absent resets high so a cold start never looks like an inserted module.
  localparam logic [SYNC_W-1:0] SYNC_RST = SYNC_W'(1 << I_NPRES);

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]   QPLL_LAST = CNT_W'(QPLL_LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   RX_LAST   = CNT_W'(RX_LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(BER_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PWR = 3'd1,
    ST_PLL_RST  = 3'd2,
    ST_PLL_WAIT = 3'd3,
    ST_TX_RST   = 3'd4,
    ST_RX_RST   = 3'd5,
    ST_RX_WAIT  = 3'd6,
    ST_LINK_UP  = 3'd7
  } state_e;

  logic [SYNC_W-1:0]  sync_meta_q, sync_meta_d;
  logic [SYNC_W-1:0]  sync_q, sync_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               qpll_reset_q, qpll_reset_d;
  logic               tx_reset_q, tx_reset_d;
  logic               rx_reset_q, rx_reset_d;
  logic               sfp_tx_disable_q, sfp_tx_disable_d;
  logic               link_up_q, link_up_d;

  logic pwrgood_s, qlock_s, npres_s, link_good;
  logic pwr_needed, lock_needed, retry_inc;

  // Two-flop synchronizers for every asynchronous status input.
  always_comb begin : sync_next
    sync_meta_d = {sfp_los, sfp_npres, rx_high_ber, rx_block_lock, qpll_lock, gtpowergood};
    sync_d      = sync_meta_q;
  end

  assign pwrgood_s = sync_q[I_PWRGOOD];
  assign qlock_s   = sync_q[I_QLOCK];
  assign npres_s   = sync_q[I_NPRES];
  assign link_good = sync_q[I_BLOCK] & ~sync_q[I_HIBER] & ~sync_q[I_LOS];

  assign pwr_needed  = (state_q != ST_IDLE) && (state_q != ST_WAIT_PWR);
  assign lock_needed = state_q inside {ST_TX_RST, ST_RX_RST, ST_RX_WAIT, ST_LINK_UP};

  always_comb begin : fsm_next
    state_d   = state_q;
    retry_inc = 1'b0;
    if (!enable || npres_s) begin
      state_d = ST_IDLE;
    end else if (pwr_needed && !pwrgood_s) begin
      state_d = ST_WAIT_PWR;
    end else if (lock_needed && !qlock_s) begin
      state_d   = ST_PLL_RST;
      retry_inc = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_WAIT_PWR;
        ST_WAIT_PWR: if (pwrgood_s) state_d = ST_PLL_RST;
        ST_PLL_RST:  if (cnt_q == HOLD_LAST) state_d = ST_PLL_WAIT;
        ST_PLL_WAIT: begin
          // Lock takes precedence over a timeout expiring in the same cycle.
          if (qlock_s) begin
            state_d = ST_TX_RST;
          end else if (cnt_q == QPLL_LAST) begin
            state_d   = ST_PLL_RST;
            retry_inc = 1'b1;
          end
        end
        ST_TX_RST:   if (cnt_q == HOLD_LAST) state_d = ST_RX_RST;
        ST_RX_RST:   if (cnt_q == HOLD_LAST) state_d = ST_RX_WAIT;
        ST_RX_WAIT: begin
          if (link_good) begin
            state_d = ST_LINK_UP;
          end else if (cnt_q == RX_LAST) begin
            state_d   = ST_RX_RST;
            retry_inc = 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (!link_good && (cnt_q == DEB_LAST)) begin
            state_d   = ST_RX_RST;
            retry_inc = 1'b1;
          end
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Shared counter: dwell time in timed states, consecutive bad cycles in LINK_UP.
  always_comb begin : cnt_next
    cnt_d = '0;
    if (state_d == state_q) begin
      if (state_q == ST_LINK_UP) begin
        cnt_d = link_good ? '0 : cnt_q + CNT_ONE;
      end else if (pwr_needed) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin : retry_next
    retry_d = retry_q;
    if (retry_inc && (retry_q != RETRY_MAX)) begin
      retry_d = retry_q + RETRY_W'(1);
    end
  end

  // Outputs decode the next state so they move on the same edge as state.
  always_comb begin : out_decode
    qpll_reset_d     = 1'b0;
    tx_reset_d       = 1'b0;
    rx_reset_d       = 1'b0;
    sfp_tx_disable_d = 1'b0;
    link_up_d        = 1'b0;
    case (state_d)
      ST_IDLE, ST_WAIT_PWR: begin
        qpll_reset_d     = 1'b1;
        tx_reset_d       = 1'b1;
        rx_reset_d       = 1'b1;
        sfp_tx_disable_d = 1'b1;
      end
      ST_PLL_RST: begin
        qpll_reset_d = 1'b1;
        tx_reset_d   = 1'b1;
        rx_reset_d   = 1'b1;
      end
      ST_PLL_WAIT, ST_TX_RST: begin
        tx_reset_d = 1'b1;
        rx_reset_d = 1'b1;
      end
      ST_RX_RST:  rx_reset_d = 1'b1;
      ST_LINK_UP: link_up_d  = 1'b1;
      default:    link_up_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      sync_meta_q      <= SYNC_RST;
      sync_q           <= SYNC_RST;
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      retry_q          <= '0;
      qpll_reset_q     <= 1'b1;
      tx_reset_q       <= 1'b1;
      rx_reset_q       <= 1'b1;
      sfp_tx_disable_q <= 1'b1;
      link_up_q        <= 1'b0;
    end else begin
      sync_meta_q      <= sync_meta_d;
      sync_q           <= sync_d;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      retry_q          <= retry_d;
      qpll_reset_q     <= qpll_reset_d;
      tx_reset_q       <= tx_reset_d;
      rx_reset_q       <= rx_reset_d;
      sfp_tx_disable_q <= sfp_tx_disable_d;
      link_up_q        <= link_up_d;
    end
  end

  assign qpll_reset     = qpll_reset_q;
  assign tx_reset       = tx_reset_q;
  assign rx_reset       = rx_reset_q;
  assign sfp_tx_disable = sfp_tx_disable_q;
  assign link_up        = link_up_q;
  assign state          = state_q;
  assign retry_count    = retry_q;

endmodule

// File: tb/tb_eth_xcvr_link_ctrl.sv
// Self-checking bench for eth_xcvr_link_ctrl: directed scenarios plus randomized
// status toggling, compared every cycle against a behavioural reference model.
module tb_eth_xcvr_link_ctrl;

  localparam int RH = 4;
  localparam int QT = 16;
  localparam int RT = 32;
  localparam int BD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1, pg = 1'b1, lk = 1'b0, bl = 1'b1, hb = 1'b0, npres = 1'b0, los = 1'b0;
  logic       qpll_reset, tx_reset, rx_reset, sfp_tx_disable, link_up;
  logic [2:0] state;
  logic [7:0] retry_count;

  int checks = 0;
  int failures = 0;

  // Per-state output tables: bit k set means the output is high in state k.
  bit [7:0] qpll_m = 8'b0000_0111;
  bit [7:0] tx_m   = 8'b0001_1111;
  bit [7:0] rx_m   = 8'b0011_1111;
  bit [7:0] dis_m  = 8'b0000_0011;
  bit [7:0] link_m = 8'b1000_0000;

  always #5 clk = ~clk;

  eth_xcvr_link_ctrl #(
    .RESET_HOLD(RH), .QPLL_LOCK_TIMEOUT(QT), .RX_LOCK_TIMEOUT(RT), .BER_DEBOUNCE(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .gtpowergood(pg), .qpll_lock(lk),
    .rx_block_lock(bl), .rx_high_ber(hb), .sfp_npres(npres), .sfp_los(los),
    .qpll_reset(qpll_reset), .tx_reset(tx_reset), .rx_reset(rx_reset),
    .sfp_tx_disable(sfp_tx_disable), .link_up(link_up), .state(state),
    .retry_count(retry_count)
  );

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: raw input seen two edges ago, dwell time, bad-run length.
  int       m_st = 0, m_dwell = 0, m_bad = 0, m_retry = 0;
  bit [5:0] m_s1 = 6'b010000, m_s2 = 6'b010000;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int ns;
    bit bump, good, pg_s, lk_s, np_s;
    if (!rst_n) begin
      m_st = 0; m_dwell = 0; m_bad = 0; m_retry = 0;
      m_s1 = 6'b010000; m_s2 = 6'b010000;
    end else begin
      pg_s = m_s2[0]; lk_s = m_s2[1]; np_s = m_s2[4];
      good = m_s2[2] && !m_s2[3] && !m_s2[5];
      ns = m_st; bump = 0;
      if (!en || np_s) ns = 0;
      else if (m_st >= 2 && !pg_s) ns = 1;
      else if (m_st >= 4 && !lk_s) begin ns = 2; bump = 1; end
      else begin
        case (m_st)
          0: ns = 1;
          1: if (pg_s) ns = 2;
          2: if (m_dwell + 1 >= RH) ns = 3;
          3: if (lk_s) ns = 4; else if (m_dwell + 1 >= QT) begin ns = 2; bump = 1; end
          4: if (m_dwell + 1 >= RH) ns = 5;
          5: if (m_dwell + 1 >= RH) ns = 6;
          6: if (good) ns = 7; else if (m_dwell + 1 >= RT) begin ns = 5; bump = 1; end
          7: if (!good && m_bad + 1 >= BD) begin ns = 5; bump = 1; end
          default: ns = 0;
        endcase
      end
      m_bad   = (ns == 7 && m_st == 7 && !good) ? m_bad + 1 : 0;
      m_dwell = (ns == m_st) ? m_dwell + 1 : 0;
      if (bump && m_retry < 255) m_retry++;
      m_st = ns;
      m_s2 = m_s1;
      m_s1 = {los, npres, hb, bl, lk, pg};
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    if (rst_n) begin
      chk("state", int'(state), m_st);
      chk("qpll_reset", int'(qpll_reset), int'(qpll_m[m_st]));
      chk("tx_reset", int'(tx_reset), int'(tx_m[m_st]));
      chk("rx_reset", int'(rx_reset), int'(rx_m[m_st]));
      chk("sfp_tx_disable", int'(sfp_tx_disable), int'(dis_m[m_st]));
      chk("link_up", int'(link_up), int'(link_m[m_st]));
      chk("retry_count", int'(retry_count), m_retry);
    end
  end

  task automatic wait_state(input int s, input int maxc, input string nm);
    int n = 0;
    while (int'(state) != s && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(state), s);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_state"}, int'(state), 0);
    chk({nm, "_qpll"}, int'(qpll_reset), 1);
    chk({nm, "_tx"}, int'(tx_reset), 1);
    chk({nm, "_rx"}, int'(rx_reset), 1);
    chk({nm, "_dis"}, int'(sfp_tx_disable), 1);
    chk({nm, "_link"}, int'(link_up), 0);
  endtask

  task automatic rand_phase(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) npres = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) pg    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 79) == 0)  lk    = ($urandom_range(0, 6) != 0);
      if ($urandom_range(0, 14) == 0)  bl    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0)  hb    = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 99) == 0)  los   = ($urandom_range(0, 9) == 0);
    end
  endtask

  initial begin : main
    int vis[8];
    int n3, first_e, second_e, prev, k;
    bit done, all_seen;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    chk("por_retry", int'(retry_count), 0);
    chk("por_model_state", m_st, 0);
    #1 rst_n = 1'b1;

    // Nominal bring-up with lock arriving 5 cycles into PLL_WAIT.
    foreach (vis[i]) vis[i] = 0;
    n3 = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      vis[state]++;
      if (state == 3'd3) begin
        n3++;
        if (n3 == 5) lk = 1'b1;
      end
      if (state == 3'd7) done = 1;
    end
    chk("bringup_reached_link", int'(done), 1);
    all_seen = 1;
    for (int i = 0; i < 8; i++) if (vis[i] == 0) all_seen = 0;
    chk("bringup_all_states", int'(all_seen), 1);
    chk("pll_rst_hold", vis[2], RH);
    chk("tx_rst_hold", vis[4], RH);
    chk("rx_rst_hold", vis[5], RH);
    chk("bringup_link_up", int'(link_up), 1);
    chk("bringup_retry", int'(retry_count), 0);

    // Debounce: 7 bad cycles tolerated, 8 trigger RX recovery.
    bl = 1'b0;
    repeat (7) @(negedge clk);
    bl = 1'b1;
    repeat (6) @(negedge clk);
    chk("deb7_state", int'(state), 7);
    chk("deb7_link_up", int'(link_up), 1);
    bl = 1'b0;
    repeat (8) @(negedge clk);
    bl = 1'b1;
    wait_state(5, 10, "deb8_rx_rst");
    chk("deb8_retry", int'(retry_count), 1);
    chk("deb8_tx_reset", int'(tx_reset), 0);
    chk("deb8_rx_reset", int'(rx_reset), 1);
    wait_state(7, 40, "deb8_relink");

    // QPLL lock loss in LINK_UP.
    lk = 1'b0;
    repeat (3) @(negedge clk);
    chk("lockloss_state", int'(state), 2);
    chk("lockloss_qpll", int'(qpll_reset), 1);
    chk("lockloss_tx", int'(tx_reset), 1);
    chk("lockloss_rx", int'(rx_reset), 1);
    chk("lockloss_link", int'(link_up), 0);
    chk("lockloss_retry", int'(retry_count), 2);
    lk = 1'b1;
    wait_state(7, 100, "lockloss_relink");

    // Module removal while waiting for RX.
    bl = 1'b0;
    wait_state(6, 60, "npres_rx_wait");
    npres = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("npres");
    chk("npres_retry", int'(retry_count), 3);
    npres = 1'b0;
    bl = 1'b1;
    wait_state(7, 100, "npres_relink");
    chk("npres_relink_retry", int'(retry_count), 3);

    rand_phase(3000);

    // QPLL never locks: retry saturates, PLL_RST re-entered every RH+QT cycles.
    en = 1'b1; npres = 1'b0; pg = 1'b1; bl = 1'b1; hb = 1'b0; los = 1'b0; lk = 1'b0;
    k = 0;
    while (retry_count != 8'd255 && k < 7000) begin
      @(negedge clk);
      k++;
    end
    chk("sat_reached", int'(retry_count), 255);
    first_e = -1; second_e = -1; prev = int'(state);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state == 3'd2 && prev != 2) begin
        if (first_e < 0) first_e = i;
        else if (second_e < 0) second_e = i;
      end
      prev = int'(state);
    end
    chk("pll_retry_period", second_e - first_e, RH + QT);
    chk("sat_hold", int'(retry_count), 255);
    chk("sat_tx_reset", int'(tx_reset), 1);

    // Short asynchronous reset pulse during TX_RST.
    lk = 1'b1;
    wait_state(4, 50, "reach_tx_rst");
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    chk("async_rst_retry", int'(retry_count), 0);
    #2 rst_n = 1'b1;

    rand_phase(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
